// File: rtl/acc_requant.sv
// Requantises a MAC accumulator: rounding arithmetic right shift, optional leaky-ReLU, saturate to OUT_W.
// Latency: 3 cycles from input transfer to out_valid; one item per cycle when not stalled.
// Backpressure: one global advance; a stalled output freezes all stages and drops in_ready.
module acc_requant #(
   parameter int ACC_W   = 64,
   parameter int OUT_W   = 16,
   parameter int SHIFT_W = 6
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [ACC_W-1:0]   in_acc,
   input  logic [SHIFT_W-1:0] shift,
   input  logic               leaky_en,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [OUT_W-1:0]   out_data,
   input  logic               sat_clr,
   output logic [15:0]        sat_cnt
);

   // Internal shift amount only needs to reach ACC_W-1.
   localparam int SH_W = $clog2(ACC_W);
   // Values after rounding/shifting keep one extra bit so the rounding add never overflows.
   localparam int YW = ACC_W + 1;
   localparam int unsigned SH_MAX = ACC_W - 1;
   localparam logic [ACC_W:0] ONE_W = {{ACC_W{1'b0}}, 1'b1};
   localparam logic signed [ACC_W:0] Y_MAX = {{(ACC_W + 2 - OUT_W){1'b0}}, {(OUT_W - 1){1'b1}}};
   localparam logic signed [ACC_W:0] Y_MIN = {{(ACC_W + 2 - OUT_W){1'b1}}, {(OUT_W - 1){1'b0}}};

   logic adv;

   logic               v1_q, v2_q, v3_q;
   logic [ACC_W:0]     r1_q, r1_d;
   logic [SH_W-1:0]    sh1_q, sh1_d;
   logic               lk1_q;
   logic [ACC_W:0]     rnd;

   logic signed [ACC_W:0]   y_sh;
   logic signed [ACC_W+4:0] y_ext, y13;
   logic signed [ACC_W:0]   y2_q, y2_d;

   logic             sat_hi, sat_lo;
   logic [OUT_W-1:0] out_q, out_d;
   logic [15:0]      sat_cnt_q, sat_cnt_d;

   // The only stall source is a held output; bubbles travel like items.
   assign adv       = !(v3_q && !out_ready);
   assign in_ready  = adv;
   assign out_valid = v3_q;
   assign out_data  = out_q;
   assign sat_cnt   = sat_cnt_q;

   // Stage 1 next state: clamp the shift and add the half-LSB rounding term.
   always_comb begin
      sh1_d = SH_W'(shift);
      if (32'(shift) > SH_MAX) begin
         sh1_d = SH_W'(SH_MAX);
      end
      rnd = '0;
      if (sh1_d != '0) begin
         rnd = ONE_W << (sh1_d - SH_W'(1));
      end
      r1_d = {in_acc[ACC_W-1], in_acc} + rnd;
   end

   // Stage 2 next state: arithmetic shift, then slope 13/128 on negatives when leaky is enabled.
   always_comb begin
      y_sh  = $signed(r1_q) >>> sh1_q;
      y_ext = {{4{y_sh[ACC_W]}}, y_sh};
      y13   = (y_ext <<< 3) + (y_ext <<< 2) + y_ext;
      y2_d  = y_sh;
      if (lk1_q && y_sh[ACC_W]) begin
         // Magnitude only shrinks, so the floor result always fits back in YW bits.
         y2_d = YW'(y13 >>> 7);
      end
   end

   // Stage 3 next state: saturate and count clamp events, clear winning over increment.
   always_comb begin
      sat_hi = (y2_q > Y_MAX);
      sat_lo = (y2_q < Y_MIN);
      out_d  = y2_q[OUT_W-1:0];
      if (sat_hi) begin
         out_d = Y_MAX[OUT_W-1:0];
      end else if (sat_lo) begin
         out_d = Y_MIN[OUT_W-1:0];
      end
      sat_cnt_d = sat_cnt_q;
      if (sat_clr) begin
         sat_cnt_d = '0;
      end else if (adv && v2_q && (sat_hi || sat_lo) && (sat_cnt_q != 16'hFFFF)) begin
         sat_cnt_d = sat_cnt_q + 16'd1;
      end
   end

   // Valid bits shift forward together on every advance.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         v1_q <= 1'b0;
         v2_q <= 1'b0;
         v3_q <= 1'b0;
      end else if (adv) begin
         v1_q <= in_valid;
         v2_q <= v1_q;
         v3_q <= v2_q;
      end
   end

   // Datapath registers load only on advance and only behind a valid item.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r1_q  <= '0;
         sh1_q <= '0;
         lk1_q <= 1'b0;
         y2_q  <= '0;
         out_q <= '0;
      end else if (adv) begin
         if (in_valid) begin
            r1_q  <= r1_d;
            sh1_q <= sh1_d;
            lk1_q <= leaky_en;
         end
         if (v1_q) begin
            y2_q <= y2_d;
         end
         if (v2_q) begin
            out_q <= out_d;
         end
      end
   end

   // Saturation event counter, sticky at all-ones.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sat_cnt_q <= '0;
      end else begin
         sat_cnt_q <= sat_cnt_d;
      end
   end

endmodule

// File: tb/tb_acc_requant.sv
// Bench for acc_requant: directed literal cases plus randomized traffic against a behavioural model.
// The model is an item queue with plain 128-bit arithmetic; a monitor compares every cycle.
// Inputs change 2 time units after the falling edge; the monitor samples at the falling edge.
module tb_acc_requant;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [63:0] in_acc = '0;
   logic [5:0]  shift = '0;
   logic        leaky_en = 1'b0;
   logic        out_valid;
   logic        out_ready = 1'b1;
   logic [15:0] out_data;
   logic        sat_clr = 1'b0;
   logic [15:0] sat_cnt;

   int checks = 0;
   int failures = 0;

   always #5 clk = ~clk;

   acc_requant #(.ACC_W(64), .OUT_W(16), .SHIFT_W(6)) dut (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid), .in_ready(in_ready), .in_acc(in_acc),
      .shift(shift), .leaky_en(leaky_en),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
      .sat_clr(sat_clr), .sat_cnt(sat_cnt)
   );

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   // Reference: exact integer arithmetic on a wide signed value.
   function automatic logic [15:0] ref_out(input logic [63:0] acc, input logic [5:0] sh_in,
                                           input bit lk, output bit sat);
      logic signed [127:0] a;
      int sh;
      sh = int'(sh_in);
      if (sh > 63) sh = 63;
      a = {{64{acc[63]}}, acc};
      if (sh > 0) a = a + (128'sd1 <<< (sh - 1));
      a = a >>> sh;
      if (lk && a < 0) a = (a * 13) >>> 7;
      sat = 1'b0;
      if (a > 128'sd32767) begin
         sat = 1'b1;
         a = 128'sd32767;
      end else if (a < -128'sd32768) begin
         sat = 1'b1;
         a = -128'sd32768;
      end
      return a[15:0];
   endfunction

   typedef struct {
      logic [15:0] val;
      bit          sat;
   } exp_t;

   exp_t q[$];
   exp_t cur;
   int   exp_cnt = 0;

   // Values captured just before each rising edge.
   logic        p_rst = 1'b0, p_iv = 1'b0, p_ir = 1'b0, p_ov = 1'b0, p_or = 1'b0;
   logic        p_clr = 1'b0, p_lk = 1'b0;
   logic [63:0] p_acc = '0;
   logic [5:0]  p_sh = '0;

   // Monitor: apply the last edge's events to the model, then compare.
   always @(negedge clk) begin
      bit new_sat;
      bit s;
      exp_t e;
      new_sat = 1'b0;
      if (!rst_n) begin
         q.delete();
         exp_cnt = 0;
         chk("rst_out_valid", 64'(out_valid), 64'd0);
         chk("rst_sat_cnt", 64'(sat_cnt), 64'd0);
         chk("rst_in_ready", 64'(in_ready), 64'd1);
      end else if (p_rst) begin
         if (out_valid && (!p_ov || p_or)) begin
            if (q.size() == 0) begin
               checks++;
               failures++;
               $display("FAIL unexpected_output actual=%0h required=none", out_data);
            end else begin
               cur = q.pop_front();
               new_sat = cur.sat;
            end
         end
         if (p_clr) exp_cnt = 0;
         else if (new_sat && exp_cnt != 65535) exp_cnt++;
         if (p_iv && p_ir) begin
            e.val = ref_out(p_acc, p_sh, p_lk, s);
            e.sat = s;
            q.push_back(e);
         end
         if (out_valid) chk("out_data", 64'(out_data), 64'(cur.val));
         chk("sat_cnt", 64'(sat_cnt), 64'(exp_cnt));
      end
      #4;
      p_rst = rst_n; p_iv = in_valid; p_ir = in_ready; p_ov = out_valid;
      p_or = out_ready; p_clr = sat_clr; p_lk = leaky_en; p_acc = in_acc; p_sh = shift;
      if (rst_n) chk("in_ready", 64'(in_ready), 64'(!(out_valid && !out_ready)));
   end

   task automatic tick();
      @(negedge clk);
      #2;
   endtask

   // One item into an empty pipeline; pins exact latency and a literal result.
   task automatic send_chk(input logic [63:0] acc, input logic [5:0] sh, input bit lk,
                           input logic [15:0] exp, input string name);
      tick();
      in_valid = 1'b1; in_acc = acc; shift = sh; leaky_en = lk;
      tick();
      in_valid = 1'b0;
      @(negedge clk);
      #1;
      chk({name, "_early"}, 64'(out_valid), 64'd0);
      @(negedge clk);
      #1;
      chk({name, "_valid"}, 64'(out_valid), 64'd1);
      chk(name, 64'(out_data), 64'(exp));
   endtask

   initial begin
      bit s;
      int k;
      int stall_left;
      int sent;
      int cyc;
      logic [15:0] held;
      logic signed [63:0] t;

      held = '0;
      #1;
      chk("reset_out_valid", 64'(out_valid), 64'd0);
      chk("reset_out_data", 64'(out_data), 64'd0);
      chk("reset_sat_cnt", 64'(sat_cnt), 64'd0);
      chk("reset_in_ready", 64'(in_ready), 64'd1);
      repeat (2) @(negedge clk);
      #2;
      rst_n = 1'b1;

      // Pin the model to hand-computed values.
      chk("model_round", 64'(ref_out(64'd40, 6'd4, 1'b0, s)), 64'h0003);
      chk("model_leaky", 64'(ref_out(-64'sd100, 6'd0, 1'b1, s)), 64'hFFF5);
      chk("model_sat", 64'(ref_out(64'h10000, 6'd0, 1'b0, s)), 64'h7FFF);

      // Rounding
      send_chk(64'd40, 6'd4, 1'b0, 16'h0003, "round_40");
      send_chk(-64'sd40, 6'd4, 1'b0, 16'hFFFE, "round_m40");
      send_chk(-64'sd24, 6'd4, 1'b0, 16'hFFFF, "round_m24");
      chk("round_sat_cnt", 64'(sat_cnt), 64'd0);

      // Saturation and clear priority
      send_chk(64'h10000, 6'd0, 1'b0, 16'h7FFF, "sat_pos");
      send_chk(-64'sh10000, 6'd0, 1'b0, 16'h8000, "sat_neg");
      chk("sat_cnt_two", 64'(sat_cnt), 64'd2);
      tick();
      in_valid = 1'b1; in_acc = 64'h10000; shift = 6'd0; leaky_en = 1'b0;
      tick();
      in_valid = 1'b0;
      tick();
      sat_clr = 1'b1;
      @(negedge clk);
      #1;
      chk("sat_clr_priority", 64'(sat_cnt), 64'd0);
      chk("sat_clr_item", 64'(out_data), 64'h7FFF);
      #1;
      sat_clr = 1'b0;

      // Leaky-ReLU
      send_chk(-64'sd100, 6'd0, 1'b1, 16'hFFF5, "leaky_neg");
      send_chk(64'd100, 6'd0, 1'b1, 16'h0064, "leaky_pos");
      send_chk(-64'sd100, 6'd0, 1'b0, 16'hFF9C, "leaky_off");

      // Shift extremes
      send_chk(64'h7FFF_FFFF_FFFF_FFFF, 6'd63, 1'b0, 16'h0001, "shift63_max");
      send_chk(64'h8000_0000_0000_0000, 6'd63, 1'b0, 16'hFFFF, "shift63_min");

      // Backpressure: stream 1..6, stall 5 cycles after the first output shows up
      k = 1;
      stall_left = -1;
      shift = 6'd0;
      leaky_en = 1'b0;
      for (int c = 0; c < 40; c++) begin
         @(negedge clk);
         if (out_valid && stall_left < 0) begin
            stall_left = 5;
            held = out_data;
         end
         #2;
         if (stall_left > 0) begin
            out_ready = 1'b0;
            stall_left--;
         end else begin
            out_ready = 1'b1;
         end
         in_valid = (k <= 6);
         in_acc = 64'(k);
         #1;
         if (!out_ready) begin
            chk("bp_in_ready_low", 64'(in_ready), 64'd0);
            chk("bp_hold", 64'(out_data), 64'(held));
         end
         if (in_valid && in_ready) k++;
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
      chk("bp_all_sent", 64'(k), 64'd7);
      chk("bp_drained", 64'(q.size()), 64'd0);

      // Randomized traffic
      sent = 0;
      cyc = 0;
      while (sent < 1000 && cyc < 20000) begin
         tick();
         cyc++;
         out_ready = ($urandom_range(0, 3) != 0);
         in_valid = ($urandom_range(0, 9) < 7);
         t = $signed({$urandom, $urandom});
         if ($urandom_range(0, 2) != 0) t = t >>> $urandom_range(20, 62);
         in_acc = t;
         shift = ($urandom_range(0, 1) != 0) ? 6'($urandom_range(0, 8)) : 6'($urandom_range(0, 63));
         leaky_en = ($urandom_range(0, 1) != 0);
         #1;
         if (in_valid && in_ready) sent++;
      end
      chk("rand_sent", 64'(sent), 64'd1000);
      tick();
      in_valid = 1'b0;
      out_ready = 1'b1;
      repeat (8) @(negedge clk);
      chk("rand_drained", 64'(q.size()), 64'd0);

      // Reset with three items in flight
      for (int i = 0; i < 3; i++) begin
         tick();
         in_valid = 1'b1; in_acc = 64'h20000; shift = 6'd0; leaky_en = 1'b0;
      end
      tick();
      in_valid = 1'b0;
      chk("pre_rst_valid", 64'(out_valid), 64'd1);
      chk("pre_rst_sat", 64'(sat_cnt != 16'd0), 64'd1);
      rst_n = 1'b0;
      #1;
      chk("mid_rst_out_valid", 64'(out_valid), 64'd0);
      chk("mid_rst_sat_cnt", 64'(sat_cnt), 64'd0);
      repeat (2) tick();
      rst_n = 1'b1;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         #1;
         chk("no_stale_output", 64'(out_valid), 64'd0);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/acc_requant.md
Name: acc_requant

Overview:
- Output stage placed directly after the 4-stage multiply-accumulate unit.
- Takes the 2*DATA_W-wide accumulator result and rescales it by a rounding arithmetic right shift.
- Applies an optional YOLO leaky-ReLU (slope ≈ 0.1), then saturates to the activation width.
- Fixed 3-stage pipeline with valid/ready handshake; counts saturation events for debug.

Parameters:
- ACC_W, 64: accumulator input width (2*DATA_W of the MAC).
- OUT_W, 16: output activation width, two's complement.
- SHIFT_W, 6: width of the shift-amount input.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  in_acc is valid this cycle.
- in_ready  out  1  stage accepts in_acc this cycle.
- in_acc  in  ACC_W  signed accumulator value.
- shift  in  SHIFT_W  right-shift amount; sampled together with in_acc.
- leaky_en  in  1  enables leaky-ReLU; sampled together with in_acc.
- out_valid  out  1  out_data is valid.
- out_ready  in  1  downstream accepts out_data.
- out_data  out  OUT_W  signed requantised activation.
- sat_clr  in  1  synchronous clear of sat_cnt.
- sat_cnt  out  16  saturation event counter.

Behaviour:
- Reset is asynchronous on rst_n low, released synchronously.
- Reset values: valid bits of all three stages = 0, out_valid = 0, out_data = 0, sat_cnt = 0, in_ready = 1.
- Global advance: adv = !(v3 && !out_ready). All stages load only when adv = 1. in_ready = adv (combinational).
- Transfer rules:
  - Input transfer when in_valid && in_ready.
  - Output transfer when out_valid && out_ready.
  - Bubbles do not collapse; a fully stalled pipeline holds every stage unchanged.
- Stage 1:
  - Register the transfer valid into v1.
  - Clamp shift: sh = min(shift, ACC_W-1).
  - r = sign-extended in_acc (ACC_W+1 bits) + (sh>0 ? 2^(sh-1) : 0). Round half toward +inf; no overflow possible.
  - Carry sh and leaky_en alongside.
- Stage 2:
  - y = r >>> sh (arithmetic shift).
  - If leaky_en && y<0: y = (y*13) >>> 7, with y*13 computed as (y<<3)+(y<<2)+y at ACC_W+5 bits (floor; -100 -> -11).
  - Register y and v2.
- Stage 3:
  - out_data = clamp(y, -2^(OUT_W-1), 2^(OUT_W-1)-1).
  - v3 = out_valid.
  - If a valid item loads into stage 3 and clamping occurred, sat_cnt increments; it holds at 0xFFFF (no wrap).
- sat_clr: sat_cnt = 0. It has priority over a simultaneous increment.
- Latency: 3 cycles from input transfer to out_valid with no stall; throughput 1 per cycle.
- out_data stays stable while out_valid && !out_ready.
- Reset asserted mid-operation discards all in-flight items; out_valid drops immediately.
- shift = 0: no rounding term and no shift.
- Values of shift ≥ ACC_W are clamped to ACC_W-1.

Test Plan:
- Rounding: shift=4, in_acc=40 -> out_data=3; in_acc=-40 -> -2; in_acc=-24 -> -1; each appears 3 cycles after transfer, sat_cnt=0.
- Saturation: shift=0, in_acc=0x10000 -> 32767; in_acc=-0x10000 -> -32768; sat_cnt=2. Then sat_clr=1 in the same cycle as a third saturating item -> sat_cnt=0.
- Leaky-ReLU: leaky_en=1, shift=0, in_acc=-100 -> -11; in_acc=100 -> 100; leaky_en=0 with in_acc=-100 -> -100.
- Backpressure: stream 1..6 continuously, with out_ready=0 for 5 cycles after the first output -> in_ready low during the stall, outputs 1..6 in order with no loss or duplication, out_data stable while stalled.
- Shift clamp/extremes: shift=63, in_acc=0x7FFF_FFFF_FFFF_FFFF -> 1; in_acc=min negative -> -1. Then 1000 random items (random shift, leaky_en, in_acc, out_ready) compared against a bit-accurate reference model.
- Reset mid-stream: assert rst_n=0 with 3 items in flight -> out_valid=0 immediately, sat_cnt=0, no stale output after release.
